cache_port_arbiter: RTL and testbench



---
 rtl/cache_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_cache_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter.sv
// Shares one blocking AXI-lite cache port among NREQ requesters, one transaction outstanding; AXI valids register one cycle after the grant.
// req_ready is held low while busy and resp_valid has no back-pressure; macro ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module cache_port_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_wdata,
  input  logic [NREQ*4-1:0]    req_wstrb,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic [31:0]          m_axi_araddr,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic [31:0]          m_axi_rdata,
  input  logic [1:0]           m_axi_rresp,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready,
  output logic [31:0]          m_axi_awaddr,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  output logic [31:0]          m_axi_wdata,
  output logic [3:0]           m_axi_wstrb,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  input  logic [1:0]           m_axi_bresp,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] win;
  logic             win_vld;
  logic             win_we;
  logic [31:0]      win_addr;
  logic [31:0]      win_wdata;
  logic [3:0]       win_wstrb;
  logic             w_done;
  logic             unused_resp_lsbs;
`ifndef ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0] last;
`endif

  assign unused_resp_lsbs = ^{m_axi_rresp[0], m_axi_bresp[0]};

  always_comb begin
    win     = '0;
    win_vld = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win     = PTR_W'(i);
        win_vld = 1'b1;
      end
    end
`else
    // Scan farthest-first so the requester closest after last is assigned last and wins.
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[PTR_W'((int'(last) + k) % NREQ)]) begin
        win     = PTR_W'((int'(last) + k) % NREQ);
        win_vld = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_wstrb = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PTR_W'(i) == win) begin
        win_we    = req_we[i];
        win_addr  = req_addr[32*i +: 32];
        win_wdata = req_wdata[32*i +: 32];
        win_wstrb = req_wstrb[4*i +: 4];
      end
    end
  end

  assign req_ready = (state == IDLE && win_vld) ? (NREQ'(1) << win) : '0;

  // A dropped wvalid means the write-data handshake already happened.
  assign w_done = !m_axi_wvalid || m_axi_wready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = win_we ? WR_ADDR : RD_ADDR;
      RD_ADDR: if (m_axi_arready) state_nxt = RD_DATA;
      RD_DATA: if (m_axi_rvalid) state_nxt = IDLE;
      WR_ADDR: if (m_axi_awready) state_nxt = w_done ? WR_RESP : WR_DATA;
      WR_DATA: if (m_axi_wready) state_nxt = WR_RESP;
      WR_RESP: if (m_axi_bvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner         <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last          <= PTR_W'(NREQ - 1);
`endif
      resp_valid    <= '0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      resp_valid <= '0;
      case (state)
        IDLE: if (win_vld) begin
          owner <= win;
`ifndef ARB_FIXED_PRIO_EN
          last  <= win;
`endif
          if (win_we) begin
            m_axi_awaddr  <= win_addr;
            m_axi_wdata   <= win_wdata;
            m_axi_wstrb   <= win_wstrb;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
          end else begin
            m_axi_araddr  <= win_addr;
            m_axi_arvalid <= 1'b1;
          end
        end
        RD_ADDR: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b1;
        end
        RD_DATA: if (m_axi_rvalid) begin
          m_axi_rready <= 1'b0;
          resp_rdata   <= m_axi_rdata;
          resp_err     <= m_axi_rresp[1];
          resp_valid   <= NREQ'(1) << owner;
        end
        WR_ADDR: begin
          if (m_axi_awready)           m_axi_awvalid <= 1'b0;
          if (m_axi_wready)            m_axi_wvalid  <= 1'b0;
          if (m_axi_awready && w_done) m_axi_bready  <= 1'b1;
        end
        WR_DATA: if (m_axi_wready) begin
          m_axi_wvalid <= 1'b0;
          m_axi_bready <= 1'b1;
        end
        WR_RESP: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          resp_err     <= m_axi_bresp[1];
          resp_valid   <= NREQ'(1) << owner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: expected responses are queued at request time and checked on each resp_valid pulse.
`timescale 1ns/1ps
module tb_cache_port_arbiter;
  localparam int NREQ  = 2;
  localparam int PTR_W = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, req_we, resp_valid;
  logic [NREQ*32-1:0] req_addr, req_wdata;
  logic [NREQ*4-1:0] req_wstrb;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [31:0]       m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
  logic              m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic              m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic              m_axi_bvalid, m_axi_bready;
  logic [1:0]        m_axi_rresp, m_axi_bresp;
  logic [3:0]        m_axi_wstrb;

  cache_port_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  typedef struct {
    int          owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model_rdata = '0;

  // Scoreboard side: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && resp_valid !== '0) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL resp_unexpected: resp_valid=%b with nothing expected", resp_valid);
      end else begin
        mon_e = sb.pop_front();
        if (resp_valid !== (NREQ'(1) << mon_e.owner) || resp_rdata !== mon_e.rdata || resp_err !== mon_e.err)
          $display("FAIL resp_match: got valid=%b rdata=%h err=%b, expected valid=%b rdata=%h err=%b",
                   resp_valid, resp_rdata, resp_err, NREQ'(1) << mon_e.owner, mon_e.rdata, mon_e.err);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = '0;
    tick();
    tick();
    rst = 1'b0;
    model_rdata = '0;
  endtask

  task automatic push(input int owner, input logic we, input logic [31:0] rdata, input logic err);
    exp_t e;
    if (!we) model_rdata = rdata;
    e.owner = owner;
    e.rdata = model_rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic issue(input int r, input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    int n;
    req_we[r] = we;
    req_addr[32*r +: 32] = addr;
    req_wdata[32*r +: 32] = wdata;
    req_wstrb[4*r +: 4] = wstrb;
    req_valid[r] = 1'b1;
    n = 0;
    @(negedge clk);
    while (req_ready[r] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      $display("FAIL issue_timeout: requester %0d never saw req_ready", r);
    end
    tick();
    req_valid[r] = 1'b0;
  endtask

  // Cache model for one transaction: ar_dly cycles before arready, wready w_dly cycles after awready.
  task automatic serve(input int ar_dly, input int w_dly, input logic [31:0] rdata, input logic [1:0] resp);
    int n;
    n = 0;
    while (m_axi_arvalid !== 1'b1 && m_axi_awvalid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      $display("FAIL serve_timeout: no arvalid/awvalid, got arvalid=%b awvalid=%b", m_axi_arvalid, m_axi_awvalid);
      return;
    end
    if (m_axi_arvalid === 1'b1) begin
      repeat (ar_dly) tick();
      m_axi_arready = 1'b1;
      tick();
      m_axi_arready = 1'b0;
      m_axi_rvalid = 1'b1; m_axi_rdata = rdata; m_axi_rresp = resp;
      tick();
      m_axi_rvalid = 1'b0;
    end else begin
      m_axi_awready = 1'b1;
      m_axi_wready  = (w_dly == 0);
      tick();
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      if (w_dly > 0) begin
        repeat (w_dly - 1) tick();
        m_axi_wready = 1'b1;
        tick();
        m_axi_wready = 1'b0;
      end
      m_axi_bvalid = 1'b1; m_axi_bresp = resp;
      tick();
      m_axi_bvalid = 1'b0;
    end
  endtask

  task automatic test_drained(input string name);
    repeat (2) tick();
    n_checks++;
    if (sb.size() !== 0) $display("FAIL %s_drained: %0d responses still pending, expected 0", name, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready} !== 5'b0)
      $display("FAIL reset_handshakes: got %b, expected 00000",
               {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready});
    else n_pass++;
    n_checks++;
    if (resp_valid !== '0 || resp_err !== 1'b0 || resp_rdata !== '0)
      $display("FAIL reset_resp: got valid=%b err=%b rdata=%h, expected 0/0/0", resp_valid, resp_err, resp_rdata);
    else n_pass++;
    n_checks++;
    if (m_axi_araddr !== '0 || m_axi_awaddr !== '0 || m_axi_wdata !== '0 || m_axi_wstrb !== '0)
      $display("FAIL reset_payload: got araddr=%h awaddr=%h wdata=%h wstrb=%h, expected all 0",
               m_axi_araddr, m_axi_awaddr, m_axi_wdata, m_axi_wstrb);
    else n_pass++;
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) $display("FAIL reset_first_grant: req_ready=%b, expected 01", req_ready);
    else n_pass++;
    req_valid = '0;
    tick();
  endtask

  task automatic test_single_read();
    push(0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    issue(0, 1'b0, 32'h0000_1040, '0, '0);
    @(negedge clk);
    n_checks++;
    if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h0000_1040)
      $display("FAIL read_addr: arvalid=%b araddr=%h, expected 1 and 00001040", m_axi_arvalid, m_axi_araddr);
    else n_pass++;
    serve(3, 0, 32'hDEAD_BEEF, 2'b00);
    test_drained("single_read");
  endtask

  task automatic test_single_write();
    push(1, 1'b1, '0, 1'b0);
    issue(1, 1'b1, 32'h0010_0004, 32'h1234_5678, 4'b0011);
    @(negedge clk);
    n_checks++;
    if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1 || m_axi_awaddr !== 32'h0010_0004 ||
        m_axi_wdata !== 32'h1234_5678 || m_axi_wstrb !== 4'b0011)
      $display("FAIL write_payload: awvalid=%b wvalid=%b awaddr=%h wdata=%h wstrb=%b, expected 1 1 00100004 12345678 0011",
               m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_wdata, m_axi_wstrb);
    else n_pass++;
    serve(0, 2, '0, 2'b00);
    test_drained("single_write");
  endtask

  task automatic test_contention();
    int exp_owner;
    do_reset();
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      push(0, 1'b0, 32'h0000_0100 + i, 1'b0);
`else
      push(i % 2, 1'b0, 32'h0000_0100 + i, 1'b0);
`endif
    end
    req_we = '0;
    req_addr = {32'h0000_2000, 32'h0000_1000};
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_owner = 0;
`else
      exp_owner = i % 2;
`endif
      @(negedge clk);
      n_checks++;
      if (req_ready !== (NREQ'(1) << exp_owner))
        $display("FAIL contention_grant_%0d: req_ready=%b, expected %b", i, req_ready, NREQ'(1) << exp_owner);
      else n_pass++;
      serve(0, 0, 32'h0000_0100 + i, 2'b00);
    end
    req_valid = '0;
    test_drained("contention");
  endtask

  task automatic test_back_to_back();
    req_we = 2'b10;
    req_addr[63:32] = 32'h0000_3000;
    req_wdata[63:32] = 32'hA5A5_0000;
    req_wstrb[7:4] = 4'hF;
    for (int i = 0; i < 3; i++) push(1, 1'b1, '0, (i == 2));
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 2'b10) $display("FAIL b2b_grant_%0d: req_ready=%b, expected 10", i, req_ready);
      else n_pass++;
      serve(0, i, '0, (i == 2) ? 2'b10 : 2'b00);
    end
    req_valid = '0;
    test_drained("back_to_back");
  endtask

  task automatic test_error();
    push(0, 1'b0, 32'hCAFE_0001, 1'b1);
    issue(0, 1'b0, 32'h0000_4000, '0, '0);
    serve(0, 0, 32'hCAFE_0001, 2'b10);
    push(0, 1'b0, 32'h0000_0005, 1'b0);
    issue(0, 1'b0, 32'h0000_4004, '0, '0);
    serve(1, 0, 32'h0000_0005, 2'b00);
    test_drained("error");
  endtask

  task automatic test_stall();
    push(0, 1'b0, 32'h0000_0077, 1'b0);
    issue(0, 1'b0, 32'h0000_ABC0, '0, '0);
    req_valid = 2'b11;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h0000_ABC0 || req_ready !== 2'b00)
        $display("FAIL stall_cycle_%0d: arvalid=%b araddr=%h req_ready=%b, expected 1 0000abc0 00",
                 i, m_axi_arvalid, m_axi_araddr, req_ready);
      else n_pass++;
    end
    req_valid = '0;
    serve(0, 0, 32'h0000_0077, 2'b00);
    test_drained("stall");
  endtask

  task automatic test_reset_mid();
    issue(0, 1'b0, 32'h0000_3000, '0, '0);
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_axi_rready !== 1'b1) $display("FAIL rst_mid_rd_data: rready=%b, expected 1", m_axi_rready);
    else n_pass++;
    rst = 1'b1;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0000_0BAD;
    tick();
    rst = 1'b0;
    m_axi_rvalid = 1'b0;
    model_rdata = '0;
    @(negedge clk);
    n_checks++;
    if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready} !== 5'b0 ||
        resp_valid !== '0 || resp_err !== 1'b0 || resp_rdata !== '0 || m_axi_araddr !== '0)
      $display("FAIL rst_mid_outputs: hs=%b resp_valid=%b err=%b rdata=%h araddr=%h, expected all 0",
               {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready},
               resp_valid, resp_err, resp_rdata, m_axi_araddr);
    else n_pass++;
    req_we = '0;
    req_addr = {32'h0000_6000, 32'h0000_5000};
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) $display("FAIL rst_mid_first_grant: req_ready=%b, expected 01", req_ready);
    else n_pass++;
    push(0, 1'b0, 32'h0000_0099, 1'b0);
    tick();
    req_valid = '0;
    n_checks++;
    if (m_axi_araddr !== 32'h0000_5000) $display("FAIL rst_mid_owner_addr: araddr=%h, expected 00005000", m_axi_araddr);
    else n_pass++;
    serve(0, 0, 32'h0000_0099, 2'b00);
    test_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_error();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_contention();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
